parity_frame_checker: RTL and testbench
=======================================

// Module: parity_frame_checker
// PURPOSE
//  Receive side of the parity-framed word path. Accepts {data, parity} frames on a valid/ready stream
//  and strips the parity bit. Recomputes parity over the data and emits data plus a per-word error flag
//  through a 2-entry output FIFO. Keeps saturating frame/error counters and a sticky error flag
//  for status readout.
// PARAMETERS
//  width       8    data bits per frame; a frame is width+1 bits
//  ODD_PARITY  0    0: even parity (parity bit = ^data); 1: odd parity (parity bit = ~^data)
//  CNT_W       16   width of frame_cnt and err_cnt
// PORTS
//  clk         in   1         single clock; all logic is rising-edge
//  rst_n       in   1         synchronous reset, active-low
//  data_frame  in   width+1   [width:1] = data word, [0] = parity bit
//  in_valid    in   1         data_frame is valid
//  in_ready    out  1         checker can accept a frame
//  d_word      out  width     stripped data word at the FIFO head
//  par_err     out  1         parity mismatch flag for d_word
//  out_valid   out  1         d_word/par_err are valid
//  out_ready   in   1         downstream consumes the head
//  clr_cnt     in   1         1-cycle pulse; clears counters and the sticky flag
//  frame_cnt   out  CNT_W     accepted frames, saturating
//  err_cnt     out  CNT_W     accepted frames with par_err=1, saturating
//  err_sticky  out  1         set on the first error; held until clr_cnt or reset
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): FIFO emptied, in_ready=0 during reset.
//    out_valid=0, d_word=0, par_err=0, frame_cnt=0, err_cnt=0, err_sticky=0.
//    In the first cycle after reset, in_ready=1. Reset mid-stream drops all queued words.
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  - Check on accept: exp = ^data_frame[width:1] ^ ODD_PARITY; err = exp != data_frame[0].
//    Stored entry = {data_frame[width:1], err}.
//  - Latency: a word accepted at edge N has out_valid=1 from edge N (registered; visible in cycle N+1).
//    No combinational path from in_valid to out_valid.
//  - FIFO: 2 entries with an occupancy counter 0..2. in_ready = (occ != 2), driven from a register.
//    d_word/par_err always reflect the head entry. Outputs are held stable while out_valid & !out_ready.
//  - Simultaneous accept+pop: at occ=1, occ stays 1 and the new word becomes the head next cycle.
//    At occ=0 a pop is impossible. At occ=2 accept is impossible, so a pop alone frees a slot.
//  - Full throughput: with out_ready held at 1, one word per cycle is sustained indefinitely.
//  - Counters update on accept. frame_cnt += 1 and err_cnt += err; each saturates at 2^CNT_W-1 (no wrap).
//    err_sticky |= err.
//  - clr_cnt has priority over an accept in the same cycle:
//    frame_cnt <= accept, err_cnt <= accept&err, err_sticky <= accept&err.
//    clr_cnt does not touch the FIFO.
//  - in_valid with in_ready=0 has no effect; the frame is not sampled and the sender must hold it.
// STRUCTURE
//  - Shared package/header: parity-mode constants (PAR_EVEN=0, PAR_ODD=1) and a frame-layout define
//    (parity at bit 0, data at [width:1]), common with the transmit-side framing logic.
//  - One sub-module, parity_frame_fifo2: generic 2-entry valid/ready FIFO (params DW), holding {data, err}.
//  - Parity compare, counters and sticky flag live in this top level.
//    The parity reduction is an inline reduction XOR; no separate module.
// TESTING  (width=8, ODD_PARITY=0, CNT_W=16 unless noted)
//  1. Reset, then frame {8'hA5,1'b0} with out_ready=1 -> d_word=8'hA5, par_err=0,
//     frame_cnt=1, err_cnt=0, err_sticky=0.
//  2. Frame {8'h07,1'b0} -> par_err=1, err_cnt=1, err_sticky=1.
//     Then {8'h07,1'b1} -> par_err=0, err_sticky stays 1.
//  3. All 256 data values, each with correct and flipped parity, back-to-back, out_ready=1
//     -> 512 outputs in order, 256 errors, frame_cnt=512, in_ready never drops.
//  4. out_ready=0; push 3 frames -> in_ready falls after the 2nd accept, 3rd held.
//     Raise out_ready -> order preserved, no loss or duplicate.
//  5. CNT_W=4; 20 bad frames -> err_cnt=15 and frame_cnt=15 (saturated).
//     clr_cnt in the same cycle as a bad accept -> err_cnt=1, frame_cnt=1, err_sticky=1.
//  6. rst_n=0 for 1 cycle with occ=2 and counters nonzero -> all outputs at reset values;
//     the next frame passes normally.

Source files
------------

// File: rtl/parity_frame_pkg.sv
// Shared parity-framing definitions, common to the transmit-side framer and this receive-side checker.
// Frame layout: parity bit at bit 0, data word in [width:1].
`ifndef PARITY_FRAME_LAYOUT_SVH
`define PARITY_FRAME_LAYOUT_SVH
`define PFC_PAR_BIT  0
`define PFC_DATA_LSB 1
`endif

package parity_frame_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Number of FIFO slots in the output stage, and the matching occupancy width.
  localparam int  FIFO_DEPTH = 2;
  localparam int  OCC_W      = 2;

  // Map an integer parity-mode parameter onto the mode constant.
  function automatic logic par_mode(input int odd_parity);
    return (odd_parity != 0) ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/parity_frame_fifo2.sv
// Generic 2-entry valid/ready FIFO with registered ready/valid; slot 0 is always the head.
module parity_frame_fifo2
  import parity_frame_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [OCC_W-1:0] OCC_EMPTY = '0;
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DW-1:0]    mem0_q, mem0_d;
  logic [DW-1:0]    mem1_q, mem1_d;
  logic             room_q, room_d;
  logic             vld_q, vld_d;
  logic             push, pop;

  assign push      = in_valid & in_ready;
  assign pop       = vld_q & out_ready;
  // room_q resets to 1 so ready rises in the very first cycle after reset is released.
  assign in_ready  = room_q & rst_n;
  assign out_valid = vld_q;
  assign out_data  = mem0_q;

  always_comb begin
    occ_d  = occ_q;
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == OCC_EMPTY) mem0_d = in_data;
        else                    mem1_d = in_data;
        occ_d = occ_q + OCC_ONE;
      end
      2'b01: begin
        if (occ_q == OCC_FULL) mem0_d = mem1_q;
        occ_d = occ_q - OCC_ONE;
      end
      2'b11: begin
        // Only reachable at occupancy 1: the incoming word replaces the departing head.
        mem0_d = in_data;
      end
      default: ;
    endcase
    room_d = (occ_d != OCC_FULL);
    vld_d  = (occ_d != OCC_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      mem0_q <= '0;
      mem1_q <= '0;
      room_q <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      room_q <= room_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Receive-side parity checker: strips the parity bit, flags mismatches per word through a
// 2-entry output FIFO, and keeps saturating frame/error counters plus a sticky error flag.
module parity_frame_checker
  import parity_frame_pkg::*;
#(
  parameter int width      = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width:0]   data_frame,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] d_word,
  output logic             par_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam logic             PAR_MODE = par_mode(ODD_PARITY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [width-1:0] rx_data;
  logic             rx_par;
  logic             calc_err;
  logic             accept;

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;

  assign rx_data  = data_frame[width:`PFC_DATA_LSB];
  assign rx_par   = data_frame[`PFC_PAR_BIT];
  assign calc_err = ((^rx_data) ^ PAR_MODE) != rx_par;
  assign accept   = in_valid & in_ready;

  parity_frame_fifo2 #(
    .DW (width + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({rx_data, calc_err}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  ({d_word, par_err}),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // A clear coinciding with an accept restarts the counts from that frame rather than from zero.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr_cnt) begin
      frame_cnt_d  = accept ? CNT_ONE : '0;
      err_cnt_d    = (accept & calc_err) ? CNT_ONE : '0;
      err_sticky_d = accept & calc_err;
    end else if (accept) begin
      if (frame_cnt_q != CNT_MAX)             frame_cnt_d = frame_cnt_q + CNT_ONE;
      if (calc_err && (err_cnt_q != CNT_MAX)) err_cnt_d   = err_cnt_q + CNT_ONE;
      err_sticky_d = err_sticky_q | calc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: scoreboarded output stream plus counter/flag checks,
// with a second instance at CNT_W=4 for counter saturation.
module tb_parity_frame_checker;

  logic        clk;
  logic        rst_n;
  logic [8:0]  data_frame;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  d_word;
  logic        par_err;
  logic        out_valid;
  logic        out_ready;
  logic        clr_cnt;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  logic        err_sticky;

  logic [8:0]  s_frame;
  logic        s_valid;
  logic        s_irdy;
  logic [7:0]  s_dword;
  logic        s_perr;
  logic        s_oval;
  logic        s_clr;
  logic [3:0]  s_fcnt;
  logic [3:0]  s_ecnt;
  logic        s_stk;

  int vectors     = 0;
  int miscompares = 0;
  logic [8:0] sb[$];

  parity_frame_checker #(.width(8), .ODD_PARITY(0), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_frame (data_frame),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d_word     (d_word),
    .par_err    (par_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_cnt    (clr_cnt),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  parity_frame_checker #(.width(8), .ODD_PARITY(0), .CNT_W(4)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_frame (s_frame),
    .in_valid   (s_valid),
    .in_ready   (s_irdy),
    .d_word     (s_dword),
    .par_err    (s_perr),
    .out_valid  (s_oval),
    .out_ready  (1'b1),
    .clr_cnt    (s_clr),
    .frame_cnt  (s_fcnt),
    .err_cnt    (s_ecnt),
    .err_sticky (s_stk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change only at posedge+1, so negedge values equal those seen at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_output", {23'd0, d_word, par_err}, 32'h1ff);
      else                check("out_word", {23'd0, d_word, par_err}, {23'd0, sb.pop_front()});
    end
    if (rst_n && in_valid && in_ready)
      sb.push_back({data_frame[8:1], (^data_frame[8:1]) != data_frame[0]});
  end

  task automatic send(input logic [7:0] d, input logic p);
    int n = 0;
    data_frame = {d, p};
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    data_frame = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_cnt    = 1'b0;
    s_frame    = '0;
    s_valid    = 1'b0;
    s_clr      = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),   32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_d_word",    32'(d_word),     32'd0);
    check("rst_par_err",   32'(par_err),    32'd0);
    check("rst_frame_cnt", 32'(frame_cnt),  32'd0);
    check("rst_err_cnt",   32'(err_cnt),    32'd0);
    check("rst_sticky",    32'(err_sticky), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single good frame
    send(8'hA5, 1'b0);
    check("t1_out_valid", 32'(out_valid),  32'd1);
    check("t1_d_word",    32'(d_word),     32'hA5);
    check("t1_par_err",   32'(par_err),    32'd0);
    check("t1_frame_cnt", 32'(frame_cnt),  32'd1);
    check("t1_err_cnt",   32'(err_cnt),    32'd0);
    check("t1_sticky",    32'(err_sticky), 32'd0);

    // 2: bad then good parity; sticky holds
    send(8'h07, 1'b0);
    send(8'h07, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("t2_frame_cnt", 32'(frame_cnt),  32'd3);
    check("t2_err_cnt",   32'(err_cnt),    32'd1);
    check("t2_sticky",    32'(err_sticky), 32'd1);

    pulse_clr();
    check("clr_frame_cnt", 32'(frame_cnt),  32'd0);
    check("clr_err_cnt",   32'(err_cnt),    32'd0);
    check("clr_sticky",    32'(err_sticky), 32'd0);

    // 3: exhaustive data, correct and flipped parity, back-to-back
    for (int i = 0; i < 256; i++) begin
      check("t3_in_ready", 32'(in_ready), 32'd1);
      send(8'(i), ^(8'(i)));
      check("t3_in_ready", 32'(in_ready), 32'd1);
      send(8'(i), ~^(8'(i)));
    end
    repeat (3) @(posedge clk);
    #1;
    check("t3_frame_cnt", 32'(frame_cnt),  32'd512);
    check("t3_err_cnt",   32'(err_cnt),    32'd256);
    check("t3_sticky",    32'(err_sticky), 32'd1);
    check("t3_sb_drained", 32'(sb.size()), 32'd0);

    // 4: backpressure fills the FIFO, third frame held
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check("t4_full_in_ready", 32'(in_ready),  32'd0);
    check("t4_full_valid",    32'(out_valid), 32'd1);
    check("t4_full_head",     32'(d_word),    32'h11);
    data_frame = {8'h33, 1'b0};
    in_valid   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_held_in_ready", 32'(in_ready), 32'd0);
    check("t4_held_head",     32'(d_word),   32'h11);
    out_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t4_reopen", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4_sb_drained", 32'(sb.size()), 32'd0);
    check("t4_out_valid",  32'(out_valid), 32'd0);

    // 5: saturation at CNT_W=4, then clear coincident with a bad accept
    s_frame = {8'h01, 1'b0};
    s_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("t5_sat_frame_cnt", 32'(s_fcnt), 32'd15);
    check("t5_sat_err_cnt",   32'(s_ecnt), 32'd15);
    check("t5_sat_sticky",    32'(s_stk),  32'd1);
    s_clr   = 1'b1;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_clr   = 1'b0;
    s_valid = 1'b0;
    check("t5_clr_frame_cnt", 32'(s_fcnt), 32'd1);
    check("t5_clr_err_cnt",   32'(s_ecnt), 32'd1);
    check("t5_clr_sticky",    32'(s_stk),  32'd1);

    // 6: reset with FIFO full and counters nonzero
    out_ready = 1'b0;
    send(8'h44, 1'b1);
    send(8'h55, 1'b0);
    check("t6_full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("t6_rst_in_ready",  32'(in_ready),   32'd0);
    check("t6_rst_out_valid", 32'(out_valid),  32'd0);
    check("t6_rst_d_word",    32'(d_word),     32'd0);
    check("t6_rst_par_err",   32'(par_err),    32'd0);
    check("t6_rst_frame_cnt", 32'(frame_cnt),  32'd0);
    check("t6_rst_err_cnt",   32'(err_cnt),    32'd0);
    check("t6_rst_sticky",    32'(err_sticky), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t6_post_in_ready", 32'(in_ready), 32'd1);
    send(8'h3C, 1'b0);
    check("t6_d_word",    32'(d_word),    32'h3C);
    check("t6_par_err",   32'(par_err),   32'd0);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
